sum_tx_sequencer: RTL
=====================

SUM_TX_SEQUENCER -- requirements
Module: sum_tx_sequencer

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of synchronizer flops on each asynchronous input (save_a_n, save_b_n, uart_tx_en); legal values 2-3.
REQ-002 Parameter MSG_CRLF, default 1: 1 appends CR and LF to each message, 0 omits them.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 save_a_n  input  1  active-low button that latches operand A; asynchronous to clk.
REQ-006 save_b_n  input  1  active-low button that latches operand B; asynchronous to clk.
REQ-007 data_input  input  4  operand value, sampled when a save event fires.
REQ-008 uart_tx_en  input  1  send request; rising edge starts a message; asynchronous to clk.
REQ-009 tx_busy  input  1  busy flag from the UART transmitter, synchronous to clk.
REQ-010 tx_data  output  8  byte presented to the UART transmitter.
REQ-011 tx_start  output  1  one-cycle strobe telling the transmitter to accept tx_data.
REQ-012 a_reg  output  4  latched operand A.
REQ-013 b_reg  output  4  latched operand B.
REQ-014 sum  output  5  a_reg + b_reg, zero-extended, no overflow loss (range 0x00-0x1E).
REQ-015 seq_busy  output  1  high while a message is in progress.

Function
REQ-016 Each asynchronous input passes through a SYNC_STAGES-flop synchronizer; edge detection uses the last synchronizer stage and one delay flop.
REQ-017 A save event is a synchronized high-to-low transition of save_a_n or save_b_n.
REQ-018 A save-A event loads data_input into a_reg on the edge following detection, and a save-B event loads b_reg the same way; both load the same data_input if they fire in the same cycle.
REQ-019 sum is combinational from a_reg and b_reg, so it updates in the same cycle as the registers.
REQ-020 A send request is a synchronized low-to-high transition of uart_tx_en, and it is honoured only in the IDLE state; a request in any other state is dropped and not queued.
REQ-021 On an accepted request the block snapshots a_reg, b_reg and sum into a message buffer; save events during the message update a_reg, b_reg and sum but not the message being sent.
REQ-022 The message consists of these bytes in order: hex(A), '+', hex(B), '=', hex(sum[4]), hex(sum[3:0]), then CR (0x0D) and LF (0x0A) when MSG_CRLF=1, giving 8 bytes (6 bytes when MSG_CRLF=0).
REQ-023 Hex digits are encoded as upper-case ASCII: values 0-9 map to 0x30-0x39 and values A-F map to 0x41-0x46.
REQ-024 FSM states and transitions are: IDLE -> LOAD on request; LOAD -> START; START -> WAIT_HI; WAIT_HI -> WAIT_LO when tx_busy=1; WAIT_LO -> NEXT when tx_busy=0; NEXT -> LOAD if bytes remain, else IDLE.
REQ-025 In LOAD the byte index selects tx_data; tx_data is held stable from LOAD until the FSM leaves WAIT_LO.
REQ-026 tx_start is 1 only in the START state, for exactly one cycle per byte.
REQ-027 If tx_busy is already 1 in the START cycle, the FSM still waits in WAIT_HI for tx_busy=1 and proceeds normally.
REQ-028 The byte index is 3 bits, cleared in IDLE, and increments in NEXT; no wrap-around occurs within a message.
REQ-029 seq_busy=0 only in IDLE.
REQ-030 A new request is accepted no earlier than the first cycle back in IDLE.

Reset
REQ-031 While reset_n=0 the block holds: a_reg=0, b_reg=0, sum=0, tx_data=0x00, tx_start=0, seq_busy=0, FSM=IDLE, byte index=0.
REQ-032 While reset_n=0 all synchronizer and edge-detect flops hold the inactive level: the save inputs hold 1 and uart_tx_en holds 0, so no spurious events occur at release.
REQ-033 Reset asserted mid-message aborts the message immediately; after release the block is IDLE with no pending byte or request.

Verification
REQ-034 Scenario 1: data_input=0x7 with save_a_n pulsed low, then data_input=0x9 with save_b_n pulsed low, then a uart_tx_en rise with a UART model that keeps tx_busy high for 10 cycles per byte -> a_reg=7, b_reg=9, sum=0x10, and the bytes sent are 0x37,0x2B,0x39,0x3D,0x31,0x30,0x0D,0x0A with exactly 8 tx_start pulses.
REQ-035 Scenario 2: A=0xF and B=0xF, then a request -> sum=0x1E and the bytes sent are 0x46,0x2B,0x46,0x3D,0x31,0x45,0x0D,0x0A.
REQ-036 Scenario 3: a save-A event with data_input=0x3 during byte 2 of a message whose snapshot has A=7 -> the message still sends 0x37 for A, and a_reg=3 after the event.
REQ-037 Scenario 4: a second uart_tx_en rise while seq_busy=1 -> it is ignored, only 8 bytes are sent, and seq_busy falls once.
REQ-038 Scenario 5: reset_n pulsed low during WAIT_LO of byte 4 -> all outputs take their REQ-031 values, and there is no tx_start after release until a new request arrives.
REQ-039 Scenario 6: save_a_n and save_b_n falling in the same cycle with data_input=0x5 -> a_reg=5, b_reg=5, sum=0x0A.

Source files
------------

// File: rtl/sum_tx_sequencer.sv
// Latches two 4-bit operands from debounced buttons and, on a send request, streams
// "A+B=SS\r\n" as upper-case hex ASCII to a byte-wide UART transmitter.
module sum_tx_sequencer #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MSG_CRLF    = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       save_a_n,
  input  logic       save_b_n,
  input  logic [3:0] data_input,
  input  logic       uart_tx_en,
  input  logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       tx_start,
  output logic [3:0] a_reg,
  output logic [3:0] b_reg,
  output logic [4:0] sum,
  output logic       seq_busy
);

  localparam int unsigned MSG_LEN  = (MSG_CRLF != 0) ? 8 : 6;
  localparam logic [2:0]  LAST_IDX = 3'(MSG_LEN - 1);

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_HI, WAIT_LO, NEXT} state_t;

  state_t state, next_state;

  logic [SYNC_STAGES-1:0] sa_sync, sb_sync, en_sync;
  logic                   sa_d, sb_d, en_d;
  logic                   save_a_ev, save_b_ev, send_req;

  logic [2:0] byte_idx;
  logic [3:0] snap_a, snap_b;
  logic [4:0] snap_sum;
  logic [7:0] byte_sel;

  function automatic logic [7:0] hex_char(input logic [3:0] v);
    return (v < 4'd10) ? (8'h30 + {4'h0, v}) : (8'h37 + {4'h0, v});
  endfunction

  // Synchronizers reset to the inactive level so release never looks like an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sa_sync <= '1;
      sb_sync <= '1;
      en_sync <= '0;
      sa_d    <= 1'b1;
      sb_d    <= 1'b1;
      en_d    <= 1'b0;
    end else begin
      sa_sync <= {sa_sync[SYNC_STAGES-2:0], save_a_n};
      sb_sync <= {sb_sync[SYNC_STAGES-2:0], save_b_n};
      en_sync <= {en_sync[SYNC_STAGES-2:0], uart_tx_en};
      sa_d    <= sa_sync[SYNC_STAGES-1];
      sb_d    <= sb_sync[SYNC_STAGES-1];
      en_d    <= en_sync[SYNC_STAGES-1];
    end
  end

  assign save_a_ev = sa_d & ~sa_sync[SYNC_STAGES-1];
  assign save_b_ev = sb_d & ~sb_sync[SYNC_STAGES-1];
  assign send_req  = en_sync[SYNC_STAGES-1] & ~en_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_reg <= '0;
      b_reg <= '0;
    end else begin
      if (save_a_ev) a_reg <= data_input;
      if (save_b_ev) b_reg <= data_input;
    end
  end

  assign sum = {1'b0, a_reg} + {1'b0, b_reg};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (send_req) next_state = LOAD;
      LOAD:    next_state = START;
      START:   next_state = WAIT_HI;
      WAIT_HI: if (tx_busy) next_state = WAIT_LO;
      WAIT_LO: if (!tx_busy) next_state = NEXT;
      NEXT:    next_state = (byte_idx == LAST_IDX) ? IDLE : LOAD;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    byte_sel = 8'h00;
    case (byte_idx)
      3'd0: byte_sel = hex_char(snap_a);
      3'd1: byte_sel = 8'h2B;
      3'd2: byte_sel = hex_char(snap_b);
      3'd3: byte_sel = 8'h3D;
      3'd4: byte_sel = hex_char({3'b000, snap_sum[4]});
      3'd5: byte_sel = hex_char(snap_sum[3:0]);
      3'd6: byte_sel = 8'h0D;
      3'd7: byte_sel = 8'h0A;
      default: byte_sel = 8'h00;
    endcase
  end

  // The snapshot decouples the message in flight from later operand saves.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      byte_idx <= '0;
      snap_a   <= '0;
      snap_b   <= '0;
      snap_sum <= '0;
      tx_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          byte_idx <= '0;
          if (send_req) begin
            snap_a   <= a_reg;
            snap_b   <= b_reg;
            snap_sum <= sum;
          end
        end
        LOAD:    tx_data  <= byte_sel;
        NEXT:    byte_idx <= byte_idx + 3'd1;
        default: ;
      endcase
    end
  end

  assign tx_start = (state == START);
  assign seq_busy = (state != IDLE);

endmodule
